// File: rtl/ula_pkg.sv
// Shared ALU definitions: opcode encoding and default datapath widths.
package ula_pkg;

   localparam int ULA_W     = 2;
   localparam int ULA_OUT_W = 9;

   typedef enum logic [3:0] {
      ALU_AND   = 4'd0,
      ALU_OR    = 4'd1,
      ALU_ADD   = 4'd2,
      ALU_XOR   = 4'd3,
      ALU_SUB   = 4'd4,
      ALU_MUL   = 4'd5,
      ALU_NOR   = 4'd6,
      ALU_SLT   = 4'd7,
      ALU_SLL   = 4'd8,
      ALU_SRL   = 4'd9,
      ALU_NAND  = 4'd10,
      ALU_PASSA = 4'd11,
      ALU_PASSB = 4'd12,
      ALU_RSV13 = 4'd13,
      ALU_RSV14 = 4'd14,
      ALU_RSV15 = 4'd15
   } alu_op_t;

endpackage

// File: rtl/ula_comb.sv
// Combinational ALU datapath: result and zero flag from (ctl, a, b).
module ula_comb
   import ula_pkg::*;
#(
   parameter int W     = ULA_W,
   parameter int OUT_W = ULA_OUT_W
) (
   input  logic [3:0]       ctl_i,
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   output logic [OUT_W-1:0] res_o,
   output logic             zero_o
);

   localparam int SHW = $clog2(OUT_W);

   logic [OUT_W-1:0] a_x;
   logic [OUT_W-1:0] b_x;
   logic [2*W-1:0]   prod;
   logic [W-1:0]     nor_w;
   logic [W-1:0]     nand_w;
   logic [SHW-1:0]   sh;

   assign a_x    = {{(OUT_W-W){1'b0}}, a_i};
   assign b_x    = {{(OUT_W-W){1'b0}}, b_i};
   assign prod   = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
   // NOR/NAND invert at operand width so upper result bits stay clear
   assign nor_w  = ~(a_i | b_i);
   assign nand_w = ~(a_i & b_i);
   assign sh     = b_x[SHW-1:0];

   always_comb begin
      res_o = '0;
      case (alu_op_t'(ctl_i))
         ALU_AND:   res_o = a_x & b_x;
         ALU_OR:    res_o = a_x | b_x;
         ALU_ADD:   res_o = a_x + b_x;
         ALU_XOR:   res_o = a_x ^ b_x;
         ALU_SUB:   res_o = a_x - b_x;
         ALU_MUL:   res_o = {{(OUT_W-2*W){1'b0}}, prod};
         ALU_NOR:   res_o = {{(OUT_W-W){1'b0}}, nor_w};
         ALU_SLT:   res_o = {{(OUT_W-1){1'b0}}, (a_i < b_i)};
         ALU_SLL:   res_o = a_x << sh;
         ALU_SRL:   res_o = a_x >> b_x;
         ALU_NAND:  res_o = {{(OUT_W-W){1'b0}}, nand_w};
         ALU_PASSA: res_o = a_x;
         ALU_PASSB: res_o = b_x;
         default:   res_o = '0;
      endcase
   end

   assign zero_o = (res_o == '0);

endmodule

// File: rtl/ula_unit.sv
// Registered ALU: combinational datapath followed by the result/zero
// register, cleared asynchronously by reset.
module ula_unit
   import ula_pkg::*;
#(
   parameter int W     = ULA_W,
   parameter int OUT_W = ULA_OUT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       ALUctl,
   input  logic [W-1:0]     A,
   input  logic [W-1:0]     B,
   output logic [OUT_W-1:0] ALUOut,
   output logic             Zero
);

   logic [OUT_W-1:0] out_d;
   logic [OUT_W-1:0] out_q;
   logic             zero_d;
   logic             zero_q;

   ula_comb #(
      .W     (W),
      .OUT_W (OUT_W)
   ) u_comb (
      .ctl_i  (ALUctl),
      .a_i    (A),
      .b_i    (B),
      .res_o  (out_d),
      .zero_o (zero_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         out_q  <= out_d;
         zero_q <= zero_d;
      end
   end

   assign ALUOut = out_q;
   assign Zero   = zero_q;

endmodule

// File: tb/tb_ula_unit.sv
// Scoreboard bench for ula_unit: stimulus queues expected results,
// a monitor pops and compares them one cycle later.
module tb_ula_unit;

   logic       clk;
   logic       reset;
   logic [3:0] ALUctl;
   logic [1:0] A;
   logic [1:0] B;
   logic [8:0] ALUOut;
   logic       Zero;

   typedef struct {
      logic [8:0] res;
      logic       z;
      string      nm;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   ula_unit #(.W(2), .OUT_W(9)) dut (
      .clk    (clk),
      .reset  (reset),
      .ALUctl (ALUctl),
      .A      (A),
      .B      (B),
      .ALUOut (ALUOut),
      .Zero   (Zero)
   );

   // clock is held low at first so reset can be shown clock-free
   initial begin
      clk = 1'b0;
      #20;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [8:0] got,
                        input logic [8:0] want, input logic gz,
                        input logic wz);
      checks++;
      if (got !== want || gz !== wz) begin
         errors++;
         $display("FAIL %s: got ALUOut=%h Zero=%b, want ALUOut=%h Zero=%b",
                  nm, got, gz, want, wz);
      end
   endtask

   function automatic logic [8:0] model(input int c, input int a,
                                        input int b);
      int r;
      logic [31:0] rv;
      case (c)
         0:  r = a & b;
         1:  r = a | b;
         2:  r = a + b;
         3:  r = a ^ b;
         4:  r = a - b;
         5:  r = a * b;
         6:  r = (~(a | b)) & 3;
         7:  r = (a < b) ? 1 : 0;
         8:  r = a << b;
         9:  r = a >> b;
         10: r = (~(a & b)) & 3;
         11: r = a;
         12: r = b;
         default: r = 0;
      endcase
      rv = r;
      return rv[8:0];
   endfunction

   task automatic push(input logic [8:0] res, input logic z,
                       input string nm);
      exp_t e;
      e.res = res;
      e.z   = z;
      e.nm  = nm;
      sb.push_back(e);
   endtask

   task automatic issue(input int c, input int a, input int b,
                        input logic [8:0] res, input logic z,
                        input string nm);
      @(negedge clk);
      ALUctl = 4'(c);
      A      = 2'(a);
      B      = 2'(b);
      push(res, z, nm);
   endtask

   always @(posedge clk) begin
      #1;
      if (!reset && sb.size() > 0) begin
         mon_e = sb.pop_front();
         check(mon_e.nm, ALUOut, mon_e.res, Zero, mon_e.z);
      end
   end

   initial begin
      logic [8:0] m;
      reset  = 1'b1;
      A      = 2'd3;
      B      = 2'd1;
      ALUctl = 4'd2;
      #1;
      check("reset_noclk", ALUOut, 9'h000, Zero, 1'b1);
      #1;
      reset = 1'b0;
      push(9'd4, 1'b0, "first_add");

      issue(0, 3, 1, 9'd1, 1'b0, "and");
      issue(1, 3, 1, 9'd3, 1'b0, "or");
      issue(3, 3, 1, 9'd2, 1'b0, "xor");
      issue(4, 3, 1, 9'd2, 1'b0, "sub");
      issue(6, 3, 1, 9'd0, 1'b1, "nor");
      issue(7, 3, 1, 9'd0, 1'b1, "slt_false");
      issue(8, 3, 1, 9'd6, 1'b0, "sll1");

      issue(4, 0, 2, 9'h1FE, 1'b0, "sub_wrap");
      issue(5, 0, 2, 9'd0, 1'b1, "mul_zero");
      issue(5, 3, 3, 9'd9, 1'b0, "mul_max");

      issue(7, 0, 2, 9'd1, 1'b0, "slt_true");
      issue(9, 0, 2, 9'd0, 1'b1, "srl");
      issue(8, 3, 3, 9'd24, 1'b0, "sll3");

      issue(10, 3, 3, 9'd0, 1'b1, "nand");
      issue(11, 2, 1, 9'd2, 1'b0, "passa");
      issue(12, 2, 1, 9'd1, 1'b0, "passb");
      issue(2, 3, 3, 9'd6, 1'b0, "add_carry");

      issue(13, 3, 3, 9'd0, 1'b1, "rsv13");
      issue(14, 3, 3, 9'd0, 1'b1, "rsv14");
      issue(15, 3, 3, 9'd0, 1'b1, "rsv15");

      for (int i = 0; i < 24; i++) begin
         int c;
         int a;
         int b;
         c = int'($urandom_range(0, 15));
         a = int'($urandom_range(0, 3));
         b = int'($urandom_range(0, 3));
         m = model(c, a, b);
         issue(c, a, b, m, (m == 9'd0), "rand");
      end

      // mid-cycle reset pulse clears at once; next edge loads inputs
      issue(2, 3, 3, 9'd6, 1'b0, "pre_reset");
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midreset_clear", ALUOut, 9'h000, Zero, 1'b1);
      #1;
      reset  = 1'b0;
      A      = 2'd3;
      B      = 2'd3;
      ALUctl = 4'd5;
      push(9'd9, 1'b0, "post_release");

      // reset held across an edge blocks the load
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #2;
      check("reset_held_edge", ALUOut, 9'h000, Zero, 1'b1);
      @(negedge clk);
      reset  = 1'b0;
      A      = 2'd2;
      B      = 2'd3;
      ALUctl = 4'd1;
      push(9'd3, 1'b0, "after_held");

      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
